// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM states, line levels,
// default frame shape and the parity helper.
`timescale 1ns/1ps
package uart_tx_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_STOP_BITS = 1;

  localparam logic UART_IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Unused upper bits must be zero; they do not disturb the XOR reduction.
  function automatic logic parity_bit(input logic [BYTE_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-write handshake between io_ctl (master) and the UART transmitter (slave).
`timescale 1ns/1ps
interface uart_tx_if;
  import uart_tx_pkg::*;

  logic [BYTE_W-1:0] din;
  logic              wr;
  logic              tx_rdy;
  logic              busy;
  logic              overrun;

  modport master (output din, wr, input tx_rdy, busy, overrun);
  modport slave  (input din, wr, output tx_rdy, busy, overrun);

endinterface

// File: rtl/uart_tx.sv
// Async UART transmitter with a one-byte holding register, paced by the
// rising edge of the baud clock bclk.
`timescale 1ns/1ps
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int STOP_BITS  = DEF_STOP_BITS,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      bclk,
  uart_tx_if.slave  bus,
  output logic      tx
);

  localparam int              CW        = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]   LAST_BIT  = CW'(DATA_BITS);
  localparam logic [1:0]      LAST_STOP = 2'(STOP_BITS);
  localparam logic            ODD       = (PARITY_ODD != 0);

  state_t               state;
  logic                 bclk_q;
  logic                 tick;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shreg;
  logic                 hold_full;
  logic                 par_q;
  logic [CW-1:0]        bitcnt;
  logic [1:0]           stopcnt;
  logic                 accept;
  logic                 load;

  assign tick   = bclk & ~bclk_q;
  assign accept = bus.wr & bus.tx_rdy;
  // A new frame starts from IDLE or straight after the last stop bit.
  assign load   = tick & hold_full &
                  ((state == IDLE) | ((state == STOP) & (stopcnt >= LAST_STOP)));

  // Holding register and write handshake; tx_rdy always mirrors ~hold_full.
  // NOTE: hold is a single register, so resetting it is cheap and keeps it
  // deterministic; a real RAM-backed FIFO would be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_q      <= 1'b1;
      hold        <= '0;
      hold_full   <= 1'b0;
      bus.tx_rdy  <= 1'b1;
      bus.overrun <= 1'b0;
    end else begin
      bclk_q      <= bclk;
      bus.overrun <= bus.wr & ~bus.tx_rdy;
      if (accept) hold <= bus.din[DATA_BITS-1:0];
      hold_full   <= accept | (hold_full & ~load);
      bus.tx_rdy  <= ~(accept | (hold_full & ~load));
    end
  end

  // NOTE: every register below uses <= so all branches read the pre-edge
  // values of shreg/bitcnt/stopcnt regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= UART_IDLE_LVL;
      bus.busy <= 1'b0;
      shreg    <= '0;
      par_q    <= 1'b0;
      bitcnt   <= '0;
      stopcnt  <= '0;
    end else if (load) begin
      shreg    <= hold;
      par_q    <= parity_bit(BYTE_W'(hold), ODD);
      tx       <= 1'b0;
      bus.busy <= 1'b1;
      state    <= START;
    end else if (tick) begin
      case (state)
        START: begin
          tx     <= shreg[0];
          shreg  <= shreg >> 1;
          bitcnt <= CW'(1);
          state  <= DATA;
        end
        DATA: begin
          if (bitcnt < LAST_BIT) begin
            tx     <= shreg[0];
            shreg  <= shreg >> 1;
            bitcnt <= bitcnt + CW'(1);
          end else if (PARITY_EN != 0) begin
            tx    <= par_q;
            state <= PARITY;
          end else begin
            tx      <= UART_IDLE_LVL;
            stopcnt <= 2'd1;
            state   <= STOP;
          end
        end
        PARITY: begin
          tx      <= UART_IDLE_LVL;
          stopcnt <= 2'd1;
          state   <= STOP;
        end
        STOP: begin
          if (stopcnt < LAST_STOP) begin
            stopcnt <= stopcnt + 2'd1;
          end else begin
            tx       <= UART_IDLE_LVL;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          tx       <= UART_IDLE_LVL;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised self-checking bench for uart_tx: a mid-bit sampling receiver
// rebuilds each frame and compares it with frames built from the byte queue.
`timescale 1ns/1ps
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int CLK_P    = 20;
  localparam int BCLK_DIV = 16;
  localparam int BIT_T    = CLK_P * BCLK_DIV;
  localparam int LEN_A    = 10;
  localparam int LEN_P    = 12;

  logic clk, rst, bclk, tx_a, tx_p;
  logic mon_en;
  int   n_checks, n_pass;

  logic [15:0] got_a[$], got_p[$];
  logic [7:0]  exp_a[$], exp_p[$];
  longint      t_a[$];

  uart_tx_if bus_a ();
  uart_tx_if bus_p ();

  uart_tx dut_a (.clk(clk), .rst(rst), .bclk(bclk), .bus(bus_a), .tx(tx_a));

  uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0))
    dut_p (.clk(clk), .rst(rst), .bclk(bclk), .bus(bus_p), .tx(tx_p));

  initial begin
    clk = 1'b0;
    forever #(CLK_P/2) clk = ~clk;
  end

  initial begin
    bclk = 1'b0;
    forever begin
      repeat (BCLK_DIV/2) @(negedge clk);
      bclk = ~bclk;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference frame in line order: start, data LSB first, optional parity, then 1s.
  function automatic logic [15:0] frame_of(input logic [7:0] d, input int db,
                                           input int pe, input int po);
    logic [15:0] f;
    logic [7:0]  m;
    f    = '1;
    f[0] = 1'b0;
    m    = 8'((1 << db) - 1);
    for (int i = 0; i < db; i++) f[1+i] = d[i];
    if (pe != 0) f[1+db] = 1'(($countones(d & m) + po) % 2);
    return f;
  endfunction

  function automatic int got_count(input int sel);
    return (sel == 0) ? got_a.size() : got_p.size();
  endfunction

  initial begin : mon_a
    logic [15:0] bits;
    longint      t0;
    forever begin
      @(negedge tx_a);
      if (mon_en) begin
        t0   = $time;
        bits = '0;
        #(BIT_T/2 + CLK_P/2);
        for (int k = 0; k < LEN_A; k++) begin
          bits[k] = tx_a;
          if (k != LEN_A-1) #(BIT_T);
        end
        if (mon_en) begin
          got_a.push_back(bits);
          t_a.push_back(t0);
        end
      end
    end
  end

  initial begin : mon_p
    logic [15:0] bits;
    forever begin
      @(negedge tx_p);
      if (mon_en) begin
        bits = '0;
        #(BIT_T/2 + CLK_P/2);
        for (int k = 0; k < LEN_P; k++) begin
          bits[k] = tx_p;
          if (k != LEN_P-1) #(BIT_T);
        end
        if (mon_en) got_p.push_back(bits);
      end
    end
  end

  // Called on a falling clk edge; leaves wr low on the next falling edge.
  task automatic send(input int sel, input logic [7:0] d);
    if (sel == 0) begin bus_a.din = d; bus_a.wr = 1'b1; end
    else          begin bus_p.din = d; bus_p.wr = 1'b1; end
    @(negedge clk);
    bus_a.wr = 1'b0;
    bus_p.wr = 1'b0;
  endtask

  task automatic wait_rdy(input int sel);
    int c;
    c = 0;
    while (((sel == 0) ? bus_a.tx_rdy : bus_p.tx_rdy) !== 1'b1 && c < 30*BCLK_DIV) begin
      @(negedge clk);
      c++;
    end
    check("tx_rdy_wait", (sel == 0) ? bus_a.tx_rdy : bus_p.tx_rdy, 1'b1);
  endtask

  task automatic wait_start(input int sel, output int cyc);
    cyc = 0;
    while (((sel == 0) ? tx_a : tx_p) !== 1'b0 && cyc < 4*BCLK_DIV) begin
      @(negedge clk);
      cyc++;
    end
    check("start_bit_seen", (sel == 0) ? tx_a : tx_p, 1'b0);
  endtask

  task automatic drain(input int sel, input int n);
    int          waited, len;
    logic [15:0] mask, g, e;
    logic [7:0]  d;
    len    = (sel == 0) ? LEN_A : LEN_P;
    mask   = 16'((1 << len) - 1);
    waited = 0;
    while (got_count(sel) < n && waited < n*(len+2)*BCLK_DIV + 64) begin
      @(negedge clk);
      waited++;
    end
    check((sel == 0) ? "frames_a" : "frames_p", got_count(sel), n);
    for (int i = 0; i < n; i++) begin
      if (got_count(sel) == 0) break;
      if (sel == 0) begin
        if (exp_a.size() == 0) break;
        g = got_a.pop_front();
        d = exp_a.pop_front();
        e = frame_of(d, 8, 0, 0);
      end else begin
        if (exp_p.size() == 0) break;
        g = got_p.pop_front();
        d = exp_p.pop_front();
        e = frame_of(d, 8, 1, 0);
      end
      check($sformatf("frame%0d_%02h", sel, d), g & mask, e & mask);
    end
  endtask

  initial begin
    int          cyc;
    logic [7:0]  d;
    n_checks = 0;
    n_pass   = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    bus_a.din = '0; bus_a.wr = 1'b0;
    bus_p.din = '0; bus_p.wr = 1'b0;

    // Reset values and quiet line afterwards.
    repeat (5) @(negedge clk);
    check("rst_tx",      tx_a,          1'b1);
    check("rst_tx_rdy",  bus_a.tx_rdy,  1'b1);
    check("rst_busy",    bus_a.busy,    1'b0);
    check("rst_overrun", bus_a.overrun, 1'b0);
    check("rst_tx_p",    tx_p,          1'b1);
    rst    = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (BCLK_DIV) @(negedge clk);
      check("idle_tx", tx_a, 1'b1);
    end
    check("idle_no_frames", got_a.size(), 0);

    // Single frame, latency bound and handshake timing.
    exp_a.push_back(8'hA5);
    send(0, 8'hA5);
    check("tx_rdy_falls", bus_a.tx_rdy, 1'b0);
    wait_start(0, cyc);
    check("latency_ok", cyc <= BCLK_DIV + 2, 1'b1);
    check("tx_rdy_back", bus_a.tx_rdy, 1'b1);
    check("busy_in_frame", bus_a.busy, 1'b1);
    drain(0, 1);
    check("busy_stop_bit", bus_a.busy, 1'b1);
    repeat (BCLK_DIV + 2) @(negedge clk);
    check("busy_after", bus_a.busy, 1'b0);

    // Back-to-back frames with no idle bit between them.
    t_a.delete();
    exp_a.push_back(8'h55);
    exp_a.push_back(8'h0F);
    send(0, 8'h55);
    wait_rdy(0);
    send(0, 8'h0F);
    drain(0, 2);
    check("b2b_spacing", (t_a.size() >= 2) ? 32'(t_a[1] - t_a[0]) : 32'd0, 32'(LEN_A*BIT_T));
    repeat (2*BCLK_DIV) @(negedge clk);

    // Overrun: third write lands while hold is full and is dropped.
    exp_a.push_back(8'h01);
    exp_a.push_back(8'h02);
    send(0, 8'h01);
    wait_start(0, cyc);
    send(0, 8'h02);
    check("ovr_quiet", bus_a.overrun, 1'b0);
    check("ovr_rdy_low", bus_a.tx_rdy, 1'b0);
    send(0, 8'h03);
    check("ovr_pulse", bus_a.overrun, 1'b1);
    @(negedge clk);
    check("ovr_one_clk", bus_a.overrun, 1'b0);
    drain(0, 2);
    repeat ((LEN_A+2)*BCLK_DIV) @(negedge clk);
    check("ovr_no_third", got_a.size(), 0);

    // Asynchronous reset during data bit 4 of 8'hFF.
    mon_en = 1'b0;
    send(0, 8'hFF);
    wait_start(0, cyc);
    repeat (5*BCLK_DIV + BCLK_DIV/2) @(negedge clk);
    check("pre_rst_busy", bus_a.busy, 1'b1);
    #5;
    rst = 1'b1;
    #1;
    check("async_tx",     tx_a,         1'b1);
    check("async_busy",   bus_a.busy,   1'b0);
    check("async_tx_rdy", bus_a.tx_rdy, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    got_a.delete();
    mon_en = 1'b1;
    repeat (2*BCLK_DIV) @(negedge clk);
    check("no_resume_tx", tx_a, 1'b1);
    check("no_resume_frames", got_a.size(), 0);
    exp_a.push_back(8'h3C);
    send(0, 8'h3C);
    drain(0, 1);

    // Parity / two-stop-bit variant.
    repeat (2*BCLK_DIV) @(negedge clk);
    exp_p.push_back(8'h07);
    send(1, 8'h07);
    drain(1, 1);

    // Randomised bursts on both variants.
    for (int i = 0; i < 8; i++) begin
      wait_rdy(0);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      d = 8'($urandom);
      exp_a.push_back(d);
      send(0, d);
    end
    drain(0, 8);
    for (int i = 0; i < 5; i++) begin
      wait_rdy(1);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      d = 8'($urandom);
      exp_p.push_back(d);
      send(1, d);
    end
    drain(1, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
